// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit.
//
// A radix-2 shift-add multiplier and a restoring divider share one control
// FSM and one 2*XLEN-bit work register. Every operation takes the same
// number of cycles regardless of opcode or operand values.
//
// Ports:
//   clk     sole clock, rising edge
//   reset   synchronous active-high reset
//   start   request strobe, honoured only in IDLE or DONE
//   op      M-extension funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a       rs1 operand (multiplicand / dividend)
//   b       rs2 operand (multiplier / divisor)
//   busy    high while an operation is in flight
//   done    one-cycle pulse, result valid in that cycle
//   result  registered result, held until the next accepted start or reset

module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic [2*XLEN-1:0] work_q, work_d;
   logic [XLEN-1:0]   operand_q, operand_d;
   logic [XLEN-1:0]   a_raw_q, a_raw_d;
   logic              b_zero_q, b_zero_d;
   logic              quot_neg_q, quot_neg_d;
   logic              rem_neg_q, rem_neg_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              a_neg, b_neg;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_shifted;
   logic [XLEN-1:0]   div_rem_new;
   logic              div_qbit;
   logic [2*XLEN-1:0] div_next;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_raw, rem_raw;
   logic [XLEN-1:0]   fin_result;

   // Operand signedness and magnitudes at accept time. The magnitude of the
   // most-negative value is 2^(XLEN-1), which still fits XLEN unsigned bits.
   always_comb begin
      a_neg = 1'b0;
      b_neg = 1'b0;
      unique case (op)
         OP_MULH, OP_DIV, OP_REM: begin
            a_neg = a[XLEN-1];
            b_neg = b[XLEN-1];
         end
         OP_MULHSU: a_neg = a[XLEN-1];
         default: ;
      endcase
      mag_a = a_neg ? -a : a;
      mag_b = b_neg ? -b : b;
   end

   // One shift-add multiply step: the low half holds the multiplier and is
   // consumed LSB first, the high half accumulates with a carry bit that is
   // shifted straight back into the register.
   always_comb begin
      mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]}
               + (work_q[0] ? {1'b0, operand_q} : '0);
      mul_next = {mul_sum, work_q[XLEN-1:1]};
   end

   // One restoring divide step: the high half is the partial remainder, the
   // low half shifts dividend bits out at the top and quotient bits in at
   // the bottom. A zero divisor simply yields all-ones and is overridden.
   always_comb begin
      div_shifted = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
      if (div_shifted >= {1'b0, operand_q}) begin
         div_rem_new = XLEN'(div_shifted - {1'b0, operand_q});
         div_qbit    = 1'b1;
      end else begin
         div_rem_new = div_shifted[XLEN-1:0];
         div_qbit    = 1'b0;
      end
      div_next = {div_rem_new, work_q[XLEN-2:0], div_qbit};
   end

   // Final sign correction and divide-by-zero override. The signed overflow
   // case needs no special handling: 2^(XLEN-1) / 1 with equal signs gives
   // the most-negative pattern, and the remainder is zero.
   always_comb begin
      prod_fix = quot_neg_q ? -work_q : work_q;
      quot_raw = work_q[XLEN-1:0];
      rem_raw  = work_q[2*XLEN-1:XLEN];
      unique case (op_q)
         OP_MUL:                       fin_result = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fin_result = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:
            fin_result = b_zero_q ? '1 : (quot_neg_q ? -quot_raw : quot_raw);
         OP_REM, OP_REMU:
            fin_result = b_zero_q ? a_raw_q : (rem_neg_q ? -rem_raw : rem_raw);
         default:                      fin_result = '0;
      endcase
   end

   // Control FSM next-state logic. A start in IDLE or DONE latches the
   // operands; CALC runs exactly XLEN iterations; FIN loads the result.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      work_d     = work_q;
      operand_d  = operand_q;
      a_raw_d    = a_raw_q;
      b_zero_d   = b_zero_q;
      quot_neg_d = quot_neg_q;
      rem_neg_d  = rem_neg_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      result_d   = result_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_CALC;
               cnt_d      = '0;
               op_d       = op;
               a_raw_d    = a;
               b_zero_d   = (b == '0);
               quot_neg_d = a_neg ^ b_neg;
               rem_neg_d  = a_neg;
               busy_d     = 1'b1;
               if (op[2]) begin
                  work_d    = {{XLEN{1'b0}}, mag_a};
                  operand_d = mag_b;
               end else begin
                  work_d    = {{XLEN{1'b0}}, mag_b};
                  operand_d = mag_a;
               end
            end else begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         end
         S_CALC: begin
            work_d = op_q[2] ? div_next : mul_next;
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FIN: begin
            state_d  = S_DONE;
            result_d = fin_result;
            done_d   = 1'b1;
            busy_d   = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         work_q     <= '0;
         operand_q  <= '0;
         a_raw_q    <= '0;
         b_zero_q   <= 1'b0;
         quot_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         work_q     <= work_d;
         operand_q  <= operand_d;
         a_raw_q    <= a_raw_d;
         b_zero_q   <= b_zero_d;
         quot_neg_q <= quot_neg_d;
         rem_neg_q  <= rem_neg_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         result_q   <= result_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed testbench for muldiv_unit at XLEN=32.
//
// Drives operations with hand-computed expected results and checks result
// value, start-to-done latency, busy shape, handshake and reset behaviour.

module tb_muldiv_unit;

   localparam int XLEN = 32;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expected;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
      end
   endtask

   // Presents one request for a single edge, then scrambles the inputs so a
   // late latch would be visible in the result.
   task automatic applyStimulus(input logic [2:0] opv, input logic [31:0] av,
                                input logic [31:0] bv);
      op    = opv;
      a     = av;
      b     = bv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = OP_MULHU;
      a     = 32'hA5A5_5A5A;
      b     = 32'h0000_0000;
   endtask

   // Follows an accepted op cycle by cycle until done, optionally pulsing a
   // second start mid-operation. Returns at the negedge of the done cycle.
   task automatic waitDone(input string tag, input logic [31:0] expected,
                           input int pulseCycle);
      int cyc;
      int busyErr;
      bit got;
      cyc     = 0;
      busyErr = 0;
      got     = 1'b0;
      while (!got && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (pulseCycle != 0 && cyc == pulseCycle) begin
            start = 1'b1;
            op    = OP_DIVU;
            a     = 32'd100;
            b     = 32'd7;
         end else if (pulseCycle != 0 && cyc == pulseCycle + 1) begin
            start = 1'b0;
         end
         if (done) begin
            got = 1'b1;
            if (busy) busyErr++;
         end else if (!busy) begin
            busyErr++;
         end
      end
      checkOutput({tag, "_latency"}, 32'(cyc), 32'(XLEN + 2));
      checkOutput({tag, "_busy"}, 32'(busyErr), 32'd0);
      checkOutput({tag, "_result"}, result, expected);
   endtask

   // One cycle after done with no new start: done must drop, busy stays low.
   task automatic idleCheck(input string tag);
      @(negedge clk);
      checkOutput({tag, "_done_low"}, 32'(done), 32'd0);
      checkOutput({tag, "_busy_low"}, 32'(busy), 32'd0);
   endtask

   initial begin
      vec_t vecs [12];
      int   stale;

      vecs[0]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[2]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[3]  = '{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
      vecs[4]  = '{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
      vecs[5]  = '{OP_DIVU,   32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC};
      vecs[6]  = '{OP_REMU,   32'hFFFF_FFF9, 32'd2,         32'h0000_0001};
      vecs[7]  = '{OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF};
      vecs[8]  = '{OP_REMU,   32'd5,         32'd0,         32'h0000_0005};
      vecs[9]  = '{OP_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
      vecs[10] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      vecs[11] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

      // Reset values.
      reset = 1'b1;
      start = 1'b0;
      op    = OP_MUL;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_result", result, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // MUL with a mid-operation start that must be ignored.
      applyStimulus(OP_MUL, 32'd7, 32'hFFFF_FFFD);
      waitDone("mul_ignore_start", 32'hFFFF_FFEB, 5);
      idleCheck("mul_ignore_start");

      // Directed vector table: high-word multiplies, divides, special cases.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
         waitDone($sformatf("vec%0d", i), vecs[i].expected, 0);
         idleCheck($sformatf("vec%0d", i));
      end

      // Back-to-back: second start issued in the DONE cycle.
      applyStimulus(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
      waitDone("b2b_first", 32'h7FFF_FFFC, 0);
      applyStimulus(OP_DIVU, 32'd100, 32'd7);
      checkOutput("b2b_busy_rise", 32'(busy), 32'd1);
      checkOutput("b2b_done_fall", 32'(done), 32'd0);
      checkOutput("b2b_result_held", result, 32'h7FFF_FFFC);
      waitDone("b2b_second", 32'd14, 0);
      idleCheck("b2b_second");

      // Reset in the middle of a MUL, with a start present on the reset edge.
      applyStimulus(OP_MUL, 32'd7, 32'd3);
      for (int i = 1; i <= 9; i++) @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      op    = OP_DIVU;
      a     = 32'd50;
      b     = 32'd5;
      @(negedge clk);
      checkOutput("midreset_busy", 32'(busy), 32'd0);
      checkOutput("midreset_done", 32'(done), 32'd0);
      checkOutput("midreset_result", result, 32'd0);
      @(negedge clk);
      checkOutput("midreset_busy2", 32'(busy), 32'd0);
      reset = 1'b0;
      start = 1'b0;
      stale = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) stale++;
      end
      checkOutput("midreset_no_stale", 32'(stale), 32'd0);
      checkOutput("midreset_result_kept", result, 32'd0);
      applyStimulus(OP_DIVU, 32'd9, 32'd3);
      waitDone("after_reset", 32'd3, 0);
      idleCheck("after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
